// File: rtl/vp_spec_pkg.sv
// Shared types for the value-prediction tracker: FSM states, entry layout and
// slot-index width helper.
package vp_spec_pkg;

    localparam int VP_ADDR_WIDTH = 32;
    localparam int VP_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RECOVER  = 2'd1,
        REDIRECT = 2'd2
    } vp_state_e;

    // Entry layout follows the package widths; trackers built with other widths need a matching package.
    typedef struct packed {
        logic [VP_ADDR_WIDTH-1:0] pc;
        logic [VP_DATA_WIDTH-1:0] pred;
    } vp_entry_t;

    function automatic int vp_idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vp_spec_tracker_if.sv
// Pipeline-side bundle for the tracker: issue, resolve, checkpoint/restore,
// stall/flush, redirect and statistics.
interface vp_spec_tracker_if
    import vp_spec_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) ();
    localparam int IDW = vp_idx_width(DEPTH);

    logic                  issue_valid;
    logic                  issue_ready;
    logic [ADDR_WIDTH-1:0] issue_pc;
    logic [DATA_WIDTH-1:0] issue_pred;
    logic [IDW-1:0]        issue_id;
    logic                  resolve_valid;
    logic [DATA_WIDTH-1:0] resolve_data;
    logic                  store_valid;
    logic                  store_stall;
    logic                  ckpt_take;
    logic [IDW-1:0]        ckpt_id;
    logic                  ckpt_ack;
    logic                  restore_req;
    logic [IDW-1:0]        restore_id;
    logic                  restore_done;
    logic                  pipe_stall;
    logic                  pipe_flush;
    logic                  load_pc_we;
    logic [ADDR_WIDTH-1:0] load_pc_new;
    logic [CNT_WIDTH-1:0]  hit_cnt;
    logic [CNT_WIDTH-1:0]  miss_cnt;
    logic                  protocol_err;

    modport slave (
        input  issue_valid, issue_pc, issue_pred, resolve_valid, resolve_data,
               store_valid, ckpt_ack, restore_done,
        output issue_ready, issue_id, store_stall, ckpt_take, ckpt_id,
               restore_req, restore_id, pipe_stall, pipe_flush, load_pc_we,
               load_pc_new, hit_cnt, miss_cnt, protocol_err
    );

    modport master (
        output issue_valid, issue_pc, issue_pred, resolve_valid, resolve_data,
               store_valid, ckpt_ack, restore_done,
        input  issue_ready, issue_id, store_stall, ckpt_take, ckpt_id,
               restore_req, restore_id, pipe_stall, pipe_flush, load_pc_we,
               load_pc_new, hit_cnt, miss_cnt, protocol_err
    );

endinterface

// File: rtl/vp_spec_fifo.sv
// Program-order circular buffer of in-flight predicted loads. The head entry is
// read combinationally so it can be compared in the resolving cycle.
module vp_spec_fifo
    import vp_spec_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = vp_entry_t,
    localparam int IDW     = vp_idx_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic           i_flush,
    input  ENTRY_T         i_wr_data,
    output ENTRY_T         o_rd_data,
    output logic [IDW-1:0] o_head,
    output logic [IDW-1:0] o_tail,
    output logic [IDW:0]   o_count,
    output logic           o_full,
    output logic           o_empty
);
    ENTRY_T         r_mem [DEPTH];
    logic [IDW-1:0] r_head;
    logic [IDW-1:0] r_tail;
    logic [IDW:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (i_pop)  r_head <= r_head + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_head];
    assign o_head    = r_head;
    assign o_tail    = r_tail;
    assign o_count   = r_count;
    assign o_full    = (r_count == (IDW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/vp_spec_tracker.sv
// Tracks outstanding value-predicted loads, checks each against the returned data
// and sequences snapshot restore plus PC redirect on a misprediction.
module vp_spec_tracker
    import vp_spec_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic                clk,
    input logic                rst_n,
    vp_spec_tracker_if.slave   bus
);
    localparam int                   IDW     = vp_idx_width(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    vp_state_e             r_state;
    vp_state_e             w_state_next;
    logic                  r_ckpt_pending;
    logic                  r_protocol_err;
    logic [IDW-1:0]        r_restore_id;
    logic [ADDR_WIDTH-1:0] r_recover_pc;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    vp_entry_t      w_wr_entry;
    vp_entry_t      w_head_entry;
    logic [IDW-1:0] w_head;
    logic [IDW-1:0] w_tail;
    logic [IDW:0]   w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_running;
    logic           w_mismatch;
    logic           w_resolve_hit;
    logic           w_ready;
    logic           w_accept;

    assign w_wr_entry    = '{pc: bus.issue_pc, pred: bus.issue_pred};
    assign w_running     = (r_state == RUN);
    assign w_mismatch    = bus.resolve_valid & ~w_empty & (bus.resolve_data != w_head_entry.pred);
    assign w_resolve_hit = bus.resolve_valid & ~w_empty & ~w_mismatch;
    // rst_n gating keeps issue_ready low while reset is held.
    assign w_ready       = rst_n & w_running & ~w_full & ~r_ckpt_pending & ~w_mismatch;
    assign w_accept      = bus.issue_valid & w_ready;

    vp_spec_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (vp_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_accept),
        .i_pop     (w_resolve_hit),
        .i_flush   (w_mismatch),
        .i_wr_data (w_wr_entry),
        .o_rd_data (w_head_entry),
        .o_head    (w_head),
        .o_tail    (w_tail),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        bus.restore_req = 1'b0;
        bus.load_pc_we  = 1'b0;
        bus.load_pc_new = '0;
        bus.pipe_flush  = 1'b0;
        bus.pipe_stall  = bus.issue_valid & ~w_ready;
        case (r_state)
            RUN: begin
                if (w_mismatch) w_state_next = RECOVER;
            end
            RECOVER: begin
                bus.restore_req = 1'b1;
                bus.pipe_stall  = 1'b1;
                bus.pipe_flush  = 1'b1;
                if (bus.restore_done) w_state_next = REDIRECT;
            end
            REDIRECT: begin
                bus.load_pc_we  = 1'b1;
                bus.load_pc_new = r_recover_pc + ADDR_WIDTH'(4);
                bus.pipe_stall  = 1'b1;
                bus.pipe_flush  = 1'b1;
                w_state_next    = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

    // An accept can never coincide with a pending checkpoint, so an ack in the accept cycle is stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ckpt_pending <= 1'b0;
            r_protocol_err <= 1'b0;
            r_restore_id   <= '0;
            r_recover_pc   <= '0;
            r_hit_cnt      <= '0;
            r_miss_cnt     <= '0;
        end else begin
            if (w_mismatch)        r_ckpt_pending <= 1'b0;
            else if (w_accept)     r_ckpt_pending <= 1'b1;
            else if (bus.ckpt_ack) r_ckpt_pending <= 1'b0;

            if (bus.resolve_valid & w_empty) r_protocol_err <= 1'b1;

            if (w_mismatch) begin
                r_recover_pc <= w_head_entry.pc;
                r_restore_id <= w_head;
                if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (w_resolve_hit && r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign bus.issue_ready  = w_ready;
    assign bus.issue_id     = w_tail;
    assign bus.ckpt_take    = w_accept;
    assign bus.ckpt_id      = w_tail;
    assign bus.restore_id   = r_restore_id;
    assign bus.store_stall  = bus.store_valid & ((w_count != '0) | ~w_running);
    assign bus.hit_cnt      = r_hit_cnt;
    assign bus.miss_cnt     = r_miss_cnt;
    assign bus.protocol_err = r_protocol_err;

endmodule

// File: tb/tb_vp_spec_tracker.sv
// Bench for vp_spec_tracker: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-based model of the tracker's rules.
module tb_vp_spec_tracker;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int CMAX  = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vp_spec_tracker_if #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) bus ();

    vp_spec_tracker #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    ent_t        mq[$];
    int          m_head, m_tail, m_hits, m_misses, m_rslot;
    bit          m_pending, m_recov, m_redir, m_perr;
    logic [31:0] m_rpc;
    int          total = 0;
    int          bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head = 0; m_tail = 0; m_hits = 0; m_misses = 0; m_rslot = 0;
        m_pending = 0; m_recov = 0; m_redir = 0; m_perr = 0; m_rpc = '0;
    endtask

    task automatic drive_idle();
        bus.issue_valid = 0; bus.issue_pc = '0; bus.issue_pred = '0;
        bus.resolve_valid = 0; bus.resolve_data = '0; bus.store_valid = 0;
        bus.ckpt_ack = 0; bus.restore_done = 0;
    endtask

    // Called at posedge+1; asserts reset asynchronously and checks every output is zero.
    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #2;
        check_eq("rst_issue_ready", bus.issue_ready, 0);
        check_eq("rst_issue_id", bus.issue_id, 0);
        check_eq("rst_store_stall", bus.store_stall, 0);
        check_eq("rst_ckpt_take", bus.ckpt_take, 0);
        check_eq("rst_ckpt_id", bus.ckpt_id, 0);
        check_eq("rst_restore_req", bus.restore_req, 0);
        check_eq("rst_restore_id", bus.restore_id, 0);
        check_eq("rst_pipe_stall", bus.pipe_stall, 0);
        check_eq("rst_pipe_flush", bus.pipe_flush, 0);
        check_eq("rst_load_pc_we", bus.load_pc_we, 0);
        check_eq("rst_load_pc_new", bus.load_pc_new, 0);
        check_eq("rst_hit_cnt", bus.hit_cnt, 0);
        check_eq("rst_miss_cnt", bus.miss_cnt, 0);
        check_eq("rst_protocol_err", bus.protocol_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        $display("txn reset");
    endtask

    // One clock: drive inputs, check outputs on the falling edge, advance the model at the rising edge.
    task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] pred,
                        input bit rv, input logic [31:0] rd, input bit sv,
                        input bit ack, input bit done);
        bit running, mism, ready, take;
        bus.issue_valid = iv; bus.issue_pc = pc; bus.issue_pred = pred;
        bus.resolve_valid = rv; bus.resolve_data = rd; bus.store_valid = sv;
        bus.ckpt_ack = ack; bus.restore_done = done;
        running = !m_recov && !m_redir;
        mism    = rv && mq.size() > 0 && rd != mq[0].pred;
        ready   = running && mq.size() < DEPTH && !m_pending && !mism;
        take    = iv && ready;
        @(negedge clk);
        check_eq("issue_ready", bus.issue_ready, ready);
        check_eq("ckpt_take", bus.ckpt_take, take);
        check_eq("ckpt_id", bus.ckpt_id, m_tail);
        check_eq("issue_id", bus.issue_id, m_tail);
        check_eq("restore_req", bus.restore_req, m_recov);
        check_eq("restore_id", bus.restore_id, m_rslot);
        check_eq("load_pc_we", bus.load_pc_we, m_redir);
        check_eq("load_pc_new", bus.load_pc_new, m_redir ? m_rpc + 32'd4 : 32'd0);
        check_eq("pipe_stall", bus.pipe_stall, !running || (iv && !ready));
        check_eq("pipe_flush", bus.pipe_flush, !running);
        check_eq("store_stall", bus.store_stall, sv && (mq.size() != 0 || !running));
        check_eq("hit_cnt", bus.hit_cnt, m_hits);
        check_eq("miss_cnt", bus.miss_cnt, m_misses);
        check_eq("protocol_err", bus.protocol_err, m_perr);
        @(posedge clk);
        if (m_redir) m_redir = 0;
        else if (m_recov && done) begin m_recov = 0; m_redir = 1; end
        if (rv && mq.size() == 0) m_perr = 1;
        if (mism) begin
            $display("txn miss slot=%0d pc=%h pred=%h actual=%h", m_head, mq[0].pc, mq[0].pred, rd);
            m_rpc = mq[0].pc; m_rslot = m_head;
            if (m_misses < CMAX) m_misses++;
            mq.delete();
            m_head = 0; m_tail = 0; m_pending = 0; m_recov = 1;
        end else begin
            if (rv && mq.size() > 0) begin
                $display("txn hit slot=%0d pred=%h", m_head, rd);
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
                if (m_hits < CMAX) m_hits++;
            end
            if (take) begin
                $display("txn issue slot=%0d pc=%h pred=%h", m_tail, pc, pred);
                mq.push_back('{pc: pc, pred: pred});
                m_tail = (m_tail + 1) % DEPTH;
                m_pending = 1;
            end else if (ack) begin
                m_pending = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit sv);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, sv, 0, 0);
    endtask

    initial begin
        drive_idle();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Correct prediction retires cleanly; stores wait until it has resolved.
        step(1, 32'h100, 32'h5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 32'h5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check_eq("tp1_hit_cnt", bus.hit_cnt, 1);

        // Misprediction: restore slot 0 after three cycles, then redirect to pc+4.
        do_reset();
        step(1, 32'h200, 32'h7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h9, 0, 1, 0);
        check_eq("tp2_restore_id", bus.restore_id, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("tp2_load_pc_new", bus.load_pc_new, 32'h204);
        check_eq("tp2_miss_cnt", bus.miss_cnt, 1);
        idle(2, 0);

        // Fill to DEPTH, stall a fifth issue, then overlap resolve with issue.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 32'h300 + 32'(4 * i), 32'(10 + i), 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 1, 1, 0);
        end
        check_eq("tp3_full_ready", bus.issue_ready, 0);
        step(1, 32'h340, 32'd20, 0, 0, 0, 0, 0);
        step(1, 32'h340, 32'd20, 1, 32'd10, 0, 0, 0);
        step(1, 32'h340, 32'd20, 1, 32'd11, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'(12 + i), 1, 0, 0);
        idle(1, 1);

        // Second of three entries mispredicts; third is discarded.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1, 32'h400 + 32'(4 * (i - 1)), 32'(i), 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0, 1, 0);
        end
        step(0, 0, 0, 1, 32'd1, 0, 0, 0);
        step(0, 0, 0, 1, 32'd9, 0, 0, 0);
        check_eq("tp4_restore_id", bus.restore_id, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("tp4_load_pc_new", bus.load_pc_new, 32'h408);
        idle(1, 0);
        // Resolve while empty sets the sticky error.
        step(0, 0, 0, 1, 32'd3, 0, 0, 0);
        idle(2, 0);
        check_eq("tp5_perr_held", bus.protocol_err, 1);

        // Reset pulse in RECOVER aborts the restore.
        step(1, 32'h500, 32'd1, 0, 0, 0, 1, 0);
        step(1, 32'h504, 32'd2, 1, 32'd4, 0, 0, 0);
        idle(1, 0);
        do_reset();
        idle(2, 0);

        // Issue colliding with a mismatch is refused.
        step(1, 32'h600, 32'd1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 32'h604, 32'd2, 1, 32'd5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1, 0);

        // Random traffic; small prediction alphabet gives a mix of hits and misses.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] rd;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) rd = mq[0].pred;
            else rd = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) do_reset();
            step(bit'($urandom_range(0, 1)), $urandom, 32'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 3, rd, $urandom_range(0, 9) < 3,
                 bit'($urandom_range(0, 1)), $urandom_range(0, 9) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
